// File: rtl/fp16_to_int_converter.sv
// FP16 (1/5/10, bias 15) to signed integer converter, one alignment shift per cycle.
// Optional build macro FP2INT_RNE_EN: round to nearest-even; otherwise truncate toward zero.
module fp16_to_int_converter #(
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [15:0]          x,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] r,
    output logic                 negative,
    output logic                 zero,
    output logic                 overflow,
    output logic                 inf,
    output logic                 nan,
    output logic                 inexact
);

    localparam int CW = (OUT_WIDTH > 16) ? OUT_WIDTH + 1 : 17;
    localparam logic [OUT_WIDTH-1:0] MAX_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] MIN_NEG = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]        LIM_POS = CW'(MAX_POS);
    localparam logic [CW-1:0]        LIM_NEG = CW'(MIN_NEG);
    localparam logic [5:0]           SAT_E   = 6'(OUT_WIDTH + 14);

    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

    state_t                 state_q, state_d;
    logic                   sign_q, sign_d;
    logic [16:0]            mag_q, mag_d;
    logic                   guard_q, guard_d;
    logic                   sticky_q, sticky_d;
    logic                   left_q, left_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0]   r_q, r_d;
    logic                   neg_q, neg_d, zero_q, zero_d, ovf_q, ovf_d;
    logic                   inf_q, inf_d, nan_q, nan_d, inx_q, inx_d;

    logic [4:0]             x_exp, e_eff, rdist;
    logic [9:0]             x_man;
    logic [10:0]            m_in;
    logic                   inc, ovf_rnd, load;
    logic [16:0]            mag_rnd;
    logic [CW-1:0]          mag_ext;
    logic [OUT_WIDTH-1:0]   mag_w;

    assign x_exp = x[14:10];
    assign x_man = x[9:0];
    assign e_eff = (x_exp == 5'd0) ? 5'd1 : x_exp;
    assign m_in  = {x_exp != 5'd0, x_man};
    assign rdist = 5'd25 - e_eff;

`ifdef FP2INT_RNE_EN
    assign inc = guard_q & (sticky_q | mag_q[0]);
`else
    assign inc = 1'b0;
`endif

    assign mag_rnd = mag_q + 17'(inc);
    assign mag_ext = CW'(mag_rnd);
    assign ovf_rnd = sign_q ? (mag_ext > LIM_NEG) : (mag_ext > LIM_POS);
    assign mag_w   = mag_ext[OUT_WIDTH-1:0];

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        mag_d       = mag_q;
        guard_d     = guard_q;
        sticky_d    = sticky_q;
        left_d      = left_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        r_d         = r_q;
        neg_d       = neg_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        inf_d       = inf_q;
        nan_d       = nan_q;
        inx_d       = inx_q;
        load        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = x[15];
                    if (x_exp == 5'h1F) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        load        = 1'b1;
                        inx_d       = 1'b0;
                        nan_d       = (x_man != 10'd0);
                        inf_d       = (x_man == 10'd0);
                        ovf_d       = (x_man == 10'd0);
                        r_d         = (x_man != 10'd0) ? '0 : (x[15] ? MIN_NEG : MAX_POS);
                    end else if ({1'b0, e_eff} >= SAT_E) begin
                        // -2^(W-1) is representable exactly, so it alone does not flag overflow
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        load        = 1'b1;
                        r_d         = x[15] ? MIN_NEG : MAX_POS;
                        ovf_d       = !(x[15] && ({1'b0, e_eff} == SAT_E) && (x_man == 10'd0));
                        inf_d       = 1'b0;
                        nan_d       = 1'b0;
                        inx_d       = 1'b0;
                    end else begin
                        mag_d    = 17'(m_in);
                        guard_d  = 1'b0;
                        sticky_d = 1'b0;
                        if (e_eff >= 5'd25) begin
                            left_d = 1'b1;
                            cnt_d  = 4'(e_eff - 5'd25);
                        end else begin
                            left_d = 1'b0;
                            cnt_d  = (rdist > 5'd12) ? 4'd12 : 4'(rdist);
                        end
                        state_d = (cnt_d == 4'd0) ? ROUND : SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (left_q) begin
                    mag_d = mag_q << 1;
                end else begin
                    mag_d    = mag_q >> 1;
                    guard_d  = mag_q[0];
                    sticky_d = sticky_q | guard_q;
                end
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = ROUND;
            end
            ROUND: begin
                state_d     = DONE;
                out_valid_d = 1'b1;
                load        = 1'b1;
                ovf_d       = ovf_rnd;
                inf_d       = 1'b0;
                nan_d       = 1'b0;
                inx_d       = guard_q | sticky_q;
                if (ovf_rnd) r_d = sign_q ? MIN_NEG : MAX_POS;
                else         r_d = sign_q ? ('0 - mag_w) : mag_w;
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            neg_d  = r_d[OUT_WIDTH-1];
            zero_d = (r_d == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            guard_q     <= 1'b0;
            sticky_q    <= 1'b0;
            left_q      <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            r_q         <= '0;
            neg_q       <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            inf_q       <= 1'b0;
            nan_q       <= 1'b0;
            inx_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            guard_q     <= guard_d;
            sticky_q    <= sticky_d;
            left_q      <= left_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            r_q         <= r_d;
            neg_q       <= neg_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            inf_q       <= inf_d;
            nan_q       <= nan_d;
            inx_q       <= inx_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign r         = r_q;
    assign negative  = neg_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign inf       = inf_q;
    assign nan       = nan_q;
    assign inexact   = inx_q;

endmodule

// File: tb/tb_fp16_to_int_converter.sv
// Scoreboard bench for fp16_to_int_converter (W = 16): directed vectors, stall, busy-ignore, mid-run reset.
module tb_fp16_to_int_converter;

    localparam int W = 16;
`ifdef FP2INT_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [15:0]  x = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] r;
    logic         negative, zero, overflow, inf, nan, inexact;

    fp16_to_int_converter #(.OUT_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .x(x),
        .out_valid(out_valid), .out_ready(out_ready), .r(r), .negative(negative),
        .zero(zero), .overflow(overflow), .inf(inf), .nan(nan), .inexact(inexact)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] r;
        logic [5:0]  f;     // {negative, zero, overflow, inf, nan, inexact}
        int          due;
        logic [15:0] x;
    } exp_t;

    exp_t sbq[$];
    bit   seen = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    function automatic logic [5:0] flags_now();
        return {negative, zero, overflow, inf, nan, inexact};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    endtask

    // Monitor: first-valid cycle, then value/flags on handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sbq.size() == 0) begin
                if (out_ready) check("unexpected_output", 32'd1, 32'd0);
            end else begin
                if (!seen) begin
                    check($sformatf("latency x=%04h", sbq[0].x), cyc, sbq[0].due);
                    seen = 1'b1;
                end
                if (out_ready) begin
                    check($sformatf("r x=%04h", sbq[0].x), r, sbq[0].r);
                    check($sformatf("flags x=%04h", sbq[0].x), flags_now(), sbq[0].f);
                    void'(sbq.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] xv, input logic [15:0] er, input logic [5:0] ef, input int lat);
        exp_t e;
        for (int k = 0; k < 100 && !in_ready; k++) step();
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            in_valid = 1'b1;
            x = xv;
            e.r = er; e.f = ef; e.due = cyc + lat; e.x = xv;
            sbq.push_back(e);
            step();
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && sbq.size() != 0; k++) step();
        check("drain", sbq.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

    initial begin
        logic [15:0] snap_r;
        logic [5:0]  snap_f;
        bit          got;

        step(); step();
        check("reset out_valid", out_valid, 0);
        check("reset r", r, 0);
        check("reset flags", flags_now(), 6'b000000);
        check("reset in_ready", in_ready, 1);
        rst_n = 1'b1;
        step();

        send(16'h3C00, 16'h0001, 6'b000000, 12);
        send(16'h4100, 16'h0002, 6'b000001, 11);
        send(16'h4300, RNE ? 16'h0004 : 16'h0003, 6'b000001, 11);
        send(16'hC500, 16'hFFFB, 6'b100000, 10);
        send(16'hF800, 16'h8000, 6'b100000, 1);
        send(16'h7BFF, 16'h7FFF, 6'b001000, 1);
        send(16'hFBFF, 16'h8000, 6'b101000, 1);
        send(16'h7C00, 16'h7FFF, 6'b001100, 1);
        send(16'h7E00, 16'h0000, 6'b010010, 1);
        send(16'h0001, 16'h0000, 6'b010001, 14);
        send(16'h0000, 16'h0000, 6'b010000, 14);
        send(16'h8000, 16'h0000, 6'b010000, 14);
        send(16'h6400, 16'h0400, 6'b000000, 2);
        send(16'h77FF, 16'h7FF0, 6'b000000, 6);
        send(16'hF7FF, 16'h8010, 6'b100000, 6);
        send(16'h3E00, RNE ? 16'h0002 : 16'h0001, 6'b000001, 12);
        send(16'h3D00, 16'h0001, 6'b000001, 12);
        send(16'hBE00, RNE ? 16'hFFFE : 16'hFFFF, 6'b100001, 12);
        send(16'h3800, 16'h0000, 6'b010001, 13);
        send(16'h3A00, RNE ? 16'h0001 : 16'h0000, RNE ? 6'b000001 : 6'b010001, 13);
        send(16'hFC00, 16'h8000, 6'b101100, 1);
        drain();

        // Mid-conversion reset: outputs clear asynchronously, no result emitted.
        send(16'h3C00, 16'h0001, 6'b000000, 12);
        step(); step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst out_valid", out_valid, 0);
        check("async_rst r", r, 0);
        check("async_rst flags", flags_now(), 6'b000000);
        check("async_rst in_ready", in_ready, 1);
        sbq.delete();
        seen = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("post_rst in_ready", in_ready, 1);
        send(16'h3C00, 16'h0001, 6'b000000, 12);
        drain();

        // Stall in DONE with busy-time in_valid toggling.
        out_ready = 1'b0;
        send(16'hC500, 16'hFFFB, 6'b100000, 10);
        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            in_valid = k[0];
            x = 16'h7C00;
            step();
            got = out_valid;
        end
        in_valid = 1'b0;
        check("stall out_valid_seen", got, 1);
        snap_r = r;
        snap_f = flags_now();
        check("stall first r", snap_r, 16'hFFFB);
        for (int k = 0; k < 5; k++) begin
            step();
            check("stall r_stable", r, snap_r);
            check("stall flags_stable", flags_now(), snap_f);
            check("stall in_ready", in_ready, 0);
            check("stall out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        step();
        check("consume in_ready", in_ready, 1);
        check("consume out_valid", out_valid, 0);
        drain();
        step(); step();
        check("no_extra_result", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
